// File: rtl/current_detect_multi_phy.sv
// current_detect_multi_phy: parallel SPI reader for NUM_CH phase-current sensors on a shared SCLK/CS_n.
// Optional macro CURRENT_MULTI_AVG_EN adds a two-tap averaging filter on each stored current.
module current_detect_multi_phy #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned SCLK_DIV  = 20,
    parameter int unsigned TCSS_CYC  = 10,
    parameter int unsigned TCSON_CYC = 30,
    parameter int unsigned MAX_ERR   = 10,
    parameter int unsigned OUT_W     = 16
) (
    input  logic                    sys_clk,
    input  logic                    reset_n,
    input  logic                    detect_enable_in,
    input  logic [15:0]             pmsm_imax_in,
    input  logic [NUM_CH-1:0]       spi_data_in,
    output logic                    spi_sclk_out,
    output logic                    spi_cs_n_out,
    output logic [NUM_CH*OUT_W-1:0] current_out,
    output logic [NUM_CH*8-1:0]     state_out,
    output logic [NUM_CH-1:0]       detect_err_out,
    output logic [NUM_CH-1:0]       ch_valid_out,
    output logic                    detect_done_out
);
    localparam int unsigned HALF     = SCLK_DIV / 2;
    localparam int unsigned PER_W    = $clog2(SCLK_DIV);
    localparam int unsigned WAIT_MAX = (TCSS_CYC > TCSON_CYC) ? TCSS_CYC : TCSON_CYC;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int unsigned ERR_W    = $clog2(MAX_ERR + 1);

    typedef enum logic [2:0] {S_IDLE, S_TCSS, S_READ, S_CHECK, S_RETRY, S_PROC} state_t;
    state_t state, state_nx;

    logic [PER_W-1:0]              period, period_nx;
    logic [3:0]                    bit_cnt;
    logic [WAIT_W-1:0]             wait_cnt;
    logic [NUM_CH-1:0]             sync1, sync2;
    logic [NUM_CH-1:0][15:0]       shreg;
    logic [NUM_CH-1:0][ERR_W-1:0]  err_cnt, err_cnt_nx;
    logic [NUM_CH-1:0]             bad, oc, st_err, st_valid, st_store;
    logic [NUM_CH-1:0][7:0]        st_code;
    logic [NUM_CH-1:0][OUT_W-1:0]  cur_new, store_val;
    logic                          retry;
    logic signed [17:0]            oc_lim, oc_hi, oc_lo;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (detect_enable_in) state_nx = S_TCSS;
            S_TCSS:  if (wait_cnt == WAIT_W'(TCSS_CYC - 1)) state_nx = S_READ;
            S_READ:  if (bit_cnt == 4'd15 && period == PER_W'(SCLK_DIV - 1)) state_nx = S_CHECK;
            S_CHECK: state_nx = retry ? S_RETRY : S_PROC;
            S_RETRY: if (wait_cnt == WAIT_W'(TCSON_CYC - 1)) state_nx = S_READ;
            S_PROC:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign period_nx = (state == S_READ && period != PER_W'(SCLK_DIV - 1)) ? period + 1'b1 : '0;

    // Frame check: odd parity, empty status frames are also rejected
    always_comb begin
        retry      = 1'b0;
        bad        = '0;
        err_cnt_nx = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bad[c] = !(^shreg[c]) || (shreg[c][15] && shreg[c][13:10] == 4'd0);
            if (^shreg[c])
                err_cnt_nx[c] = '0;
            else if (err_cnt[c] == ERR_W'(MAX_ERR))
                err_cnt_nx[c] = err_cnt[c];
            else
                err_cnt_nx[c] = err_cnt[c] + 1'b1;
            if (bad[c] && err_cnt_nx[c] < ERR_W'(MAX_ERR)) retry = 1'b1;
        end
    end

    assign oc_lim = 18'({pmsm_imax_in, 4'd0});
    assign oc_hi  = 18'sd4096 + oc_lim;
    assign oc_lo  = 18'sd4096 - oc_lim;

    // Per-channel decode of the latest frame, in priority order
    always_comb begin
        oc       = '0;
        cur_new  = '0;
        st_code  = '0;
        st_err   = '0;
        st_valid = '0;
        st_store = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            oc[c] = ($signed({5'd0, shreg[c][12:0]}) > oc_hi) ||
                    ($signed({5'd0, shreg[c][12:0]}) < oc_lo);
            cur_new[c] = OUT_W'($signed({5'd0, shreg[c][12:0]}) - 18'sd4096);
            if (err_cnt[c] == ERR_W'(MAX_ERR)) begin
                st_code[c] = 8'h20;
                st_err[c]  = 1'b1;
            end else if (!shreg[c][15] && (shreg[c][13] || oc[c])) begin
                st_code[c]  = 8'h10;
                st_err[c]   = 1'b1;
                st_store[c] = 1'b1;
            end else if (shreg[c][15]) begin
                st_code[c] = {4'd0, shreg[c][13:10]};
                st_err[c]  = 1'b1;
            end else begin
                st_valid[c] = 1'b1;
                st_store[c] = 1'b1;
            end
        end
    end

`ifdef CURRENT_MULTI_AVG_EN
    logic [NUM_CH-1:0]          seen;
    logic [NUM_CH-1:0][OUT_W:0] avg_sum;

    always_comb begin
        avg_sum   = '0;
        store_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            avg_sum[c]   = (OUT_W+1)'($signed(cur_new[c])) +
                           (OUT_W+1)'($signed(current_out[c*OUT_W +: OUT_W]));
            store_val[c] = seen[c] ? OUT_W'($signed(avg_sum[c]) >>> 1) : cur_new[c];
        end
    end

    // First stored sample after reset bypasses the filter
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)              seen <= '0;
        else if (state == S_PROC)  seen <= seen | st_store;
    end
`else
    assign store_val = cur_new;
`endif

    // Bit timing, synchroniser, shift registers and parity-failure counters
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            period   <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            sync1    <= '0;
            sync2    <= '0;
            shreg    <= '0;
            err_cnt  <= '0;
        end else begin
            sync1  <= spi_data_in;
            sync2  <= sync1;
            period <= period_nx;
            case (state)
                S_TCSS, S_RETRY: wait_cnt <= (state_nx == state) ? wait_cnt + 1'b1 : '0;
                S_READ: begin
                    if (period == PER_W'(SCLK_DIV - 1)) bit_cnt <= bit_cnt + 1'b1;
                    if (period == PER_W'(HALF + 1)) begin
                        for (int c = 0; c < NUM_CH; c++) shreg[c] <= {shreg[c][14:0], sync2[c]};
                    end
                end
                S_CHECK: err_cnt <= err_cnt_nx;
                S_PROC: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (err_cnt[c] == ERR_W'(MAX_ERR)) err_cnt[c] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_sclk_out    <= 1'b0;
            spi_cs_n_out    <= 1'b1;
            current_out     <= '0;
            state_out       <= '0;
            detect_err_out  <= '0;
            ch_valid_out    <= '0;
            detect_done_out <= 1'b0;
        end else begin
            detect_err_out  <= '0;
            ch_valid_out    <= '0;
            detect_done_out <= 1'b0;
            spi_cs_n_out    <= !(state_nx inside {S_TCSS, S_READ, S_CHECK});
            spi_sclk_out    <= (state_nx == S_READ) && (period_nx < PER_W'(HALF));
            if (state == S_PROC) begin
                detect_done_out <= 1'b1;
                detect_err_out  <= st_err;
                ch_valid_out    <= st_valid;
                for (int c = 0; c < NUM_CH; c++) begin
                    state_out[c*8 +: 8] <= st_code[c];
                    if (st_store[c]) current_out[c*OUT_W +: OUT_W] <= store_val[c];
                end
            end
        end
    end
endmodule

// File: tb/tb_current_detect_multi_phy.sv
// Directed bench for current_detect_multi_phy: behavioural sensors drive DOUT from SCLK/CS_n.
module tb_current_detect_multi_phy;
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned OUT_W  = 16;

    logic                    sys_clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    detect_enable_in = 1'b0;
    logic [15:0]             pmsm_imax_in = 16'd100;
    logic [NUM_CH-1:0]       spi_data_in = '0;
    logic                    spi_sclk_out;
    logic                    spi_cs_n_out;
    logic [NUM_CH*OUT_W-1:0] current_out;
    logic [NUM_CH*8-1:0]     state_out;
    logic [NUM_CH-1:0]       detect_err_out;
    logic [NUM_CH-1:0]       ch_valid_out;
    logic                    detect_done_out;

    current_detect_multi_phy dut (
        .sys_clk          (sys_clk),
        .reset_n          (reset_n),
        .detect_enable_in (detect_enable_in),
        .pmsm_imax_in     (pmsm_imax_in),
        .spi_data_in      (spi_data_in),
        .spi_sclk_out     (spi_sclk_out),
        .spi_cs_n_out     (spi_cs_n_out),
        .current_out      (current_out),
        .state_out        (state_out),
        .detect_err_out   (detect_err_out),
        .ch_valid_out     (ch_valid_out),
        .detect_done_out  (detect_done_out)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sensor model: new frame latched on CS_n fall, next bit presented on each SCLK rise
    logic [15:0]       good_frame [NUM_CH];
    logic [15:0]       tx [NUM_CH];
    logic [NUM_CH-1:0] stuck0 = '0;
    int                corrupt_until [NUM_CH];
    int                frames = 0;
    int                bit_idx = 0;
    int                last_gap = 0;
    time               rise_t = 0;

    always @(posedge spi_cs_n_out) rise_t = $time;

    always @(negedge spi_cs_n_out) begin
        frames++;
        last_gap = int'(($time - rise_t) / 10);
        bit_idx = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (stuck0[c])                   tx[c] = 16'h0000;
            else if (frames <= corrupt_until[c]) tx[c] = good_frame[c] ^ 16'h0001;
            else                             tx[c] = good_frame[c];
        end
    end

    always @(posedge spi_sclk_out) begin
        if (bit_idx < 16) begin
            for (int c = 0; c < NUM_CH; c++) spi_data_in[c] = tx[c][15 - bit_idx];
        end
        bit_idx++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic set_frames(input logic [15:0] f0, input logic [15:0] f1, input logic [15:0] f2);
        good_frame[0] = f0;
        good_frame[1] = f1;
        good_frame[2] = f2;
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #3 reset_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #3 reset_n = 1'b1;
    endtask

    // One conversion: enable for one cycle, optionally a stray enable mid-frame, then collect pulses
    task automatic run_conv(input bit poke, output int lat, output logic [2:0] err_acc,
                            output logic [2:0] val_acc, output int n_done, output int n_frames);
        int f0;
        bit got;
        f0 = frames; err_acc = '0; val_acc = '0; n_done = 0; lat = 0; got = 1'b0;
        @(posedge sys_clk); #1;
        detect_enable_in = 1'b1;
        for (int i = 1; i <= 6000 && !got; i++) begin
            @(posedge sys_clk); #1;
            detect_enable_in = poke && (i == 100);
            err_acc |= detect_err_out;
            val_acc |= ch_valid_out;
            if (detect_done_out) begin
                got = 1'b1;
                lat = i;
                n_done++;
            end
        end
        detect_enable_in = 1'b0;
        check("done_seen", 64'(got), 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk); #1;
            n_done += int'(detect_done_out);
            err_acc |= detect_err_out;
            val_acc |= ch_valid_out;
        end
        n_frames = frames - f0;
    endtask

    task automatic expect_conv(input string tag, input bit poke, input int lat_exp, input int fr_exp,
                               input logic [2:0] err_exp, input logic [2:0] val_exp);
        int lat, nd, nf;
        logic [2:0] ea, va;
        run_conv(poke, lat, ea, va, nd, nf);
        check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        check({tag, "_frames"},  64'(nf),  64'(fr_exp));
        check({tag, "_err"},     64'(ea),  64'(err_exp));
        check({tag, "_valid"},   64'(va),  64'(val_exp));
        check({tag, "_done_cnt"}, 64'(nd), 64'd1);
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) corrupt_until[c] = 0;
        set_frames(16'h1000, 16'h1000, 16'h1000);

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_cs_n",    64'(spi_cs_n_out),    64'd1);
        check("rst_sclk",    64'(spi_sclk_out),    64'd0);
        check("rst_current", 64'(current_out),     64'd0);
        check("rst_state",   64'(state_out),       64'd0);
        check("rst_err",     64'(detect_err_out),  64'd0);
        check("rst_valid",   64'(ch_valid_out),    64'd0);
        check("rst_done",    64'(detect_done_out), 64'd0);
        #3 reset_n = 1'b1;

`ifdef CURRENT_MULTI_AVG_EN
        set_frames(16'h5064, 16'h5064, 16'h5064);
        expect_conv("avg100", 1'b0, 333, 1, 3'b000, 3'b111);
        check("avg100_cur", 64'(current_out), 64'h0064_0064_0064);
        set_frames(16'h50C8, 16'h50C8, 16'h50C8);
        expect_conv("avg200", 1'b0, 333, 1, 3'b000, 3'b111);
        check("avg200_cur", 64'(current_out), 64'h0096_0096_0096);
        do_reset();
        set_frames(16'h1000, 16'h1000, 16'h1000);
        expect_conv("avg0", 1'b0, 333, 1, 3'b000, 3'b111);
        check("avg0_cur", 64'(current_out), 64'h0000_0000_0000);
        set_frames(16'h0FFD, 16'h0FFD, 16'h0FFD);
        expect_conv("avgm3", 1'b0, 333, 1, 3'b000, 3'b111);
        check("avgm3_cur", 64'(current_out), 64'hFFFE_FFFE_FFFE);
        do_reset();
`endif

        // Nominal: zero current on all channels, no retry
        set_frames(16'h1000, 16'h1000, 16'h1000);
        expect_conv("nominal", 1'b0, 333, 1, 3'b000, 3'b111);
        check("nominal_state", 64'(state_out), 64'h000000);

        // Status frame on ch0, bit13 fault on ch1, small positive current on ch2
        set_frames(16'h8C00, 16'h7000, 16'h1005);
        expect_conv("status", 1'b0, 333, 1, 3'b011, 3'b100);
        check("status_state", 64'(state_out), 64'h001003);
`ifndef CURRENT_MULTI_AVG_EN
        check("status_cur", 64'(current_out), 64'h0005_0000_0000);
`endif

        // Overcurrent window edges with imax=100 (limit 1600)
        pmsm_imax_in = 16'd100;
        set_frames(16'h1641, 16'h5640, 16'h09BF);
        expect_conv("oc", 1'b0, 333, 1, 3'b101, 3'b010);
        check("oc_state", 64'(state_out), 64'h100010);
`ifndef CURRENT_MULTI_AVG_EN
        check("oc_cur", 64'(current_out), 64'hF9BF_0640_0641);
`endif

        // One parity error on ch1 forces exactly one retry
        set_frames(16'h1000, 16'h5007, 16'h1000);
        corrupt_until[1] = frames + 1;
        expect_conv("retry", 1'b0, 684, 2, 3'b000, 3'b111);
        check("retry_gap", 64'(last_gap), 64'd30);
        check("retry_state", 64'(state_out), 64'h000000);
`ifndef CURRENT_MULTI_AVG_EN
        check("retry_cur", 64'(current_out), 64'h0000_0007_0000);
`endif

        // ch2 stuck low: disconnect after MAX_ERR frames; stray enable mid-frame ignored
        set_frames(16'h1003, 16'h1000, 16'h1000);
        stuck0 = 3'b100;
        expect_conv("stuck", 1'b1, 3492, 10, 3'b100, 3'b011);
        check("stuck_state", 64'(state_out), 64'h200000);
        check("stuck_cs_idle", 64'(spi_cs_n_out), 64'd1);
`ifndef CURRENT_MULTI_AVG_EN
        check("stuck_cur", 64'(current_out), 64'h0000_0000_0003);
`endif
        // Counter must have been cleared: a second disconnect again takes the full retry budget
        expect_conv("stuck2", 1'b0, 3492, 10, 3'b100, 3'b011);
        stuck0 = 3'b000;

        // Asynchronous reset during bit 7 of READ
        set_frames(16'h1009, 16'h1000, 16'h1000);
        @(posedge sys_clk); #1;
        detect_enable_in = 1'b1;
        @(posedge sys_clk); #1;
        detect_enable_in = 1'b0;
        repeat (154) @(posedge sys_clk);
        #3;
        check("mid_cs_low",   64'(spi_cs_n_out), 64'd0);
        check("mid_sclk_high", 64'(spi_sclk_out), 64'd1);
        reset_n = 1'b0;
        #1;
        check("arst_cs_n",  64'(spi_cs_n_out),    64'd1);
        check("arst_sclk",  64'(spi_sclk_out),    64'd0);
        check("arst_done",  64'(detect_done_out), 64'd0);
        repeat (2) @(posedge sys_clk);
        #3 reset_n = 1'b1;
        expect_conv("after_rst", 1'b0, 333, 1, 3'b000, 3'b111);
        check("after_rst_state", 64'(state_out), 64'h000000);
`ifndef CURRENT_MULTI_AVG_EN
        check("after_rst_cur", 64'(current_out), 64'h0000_0000_0009);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
